// File: rtl/bcd_mod_counter_if.sv
// Control and data bundle for bcd_mod_counter: count/load strobes in,
// BCD digits and wrap/error pulses out.
interface bcd_mod_counter_if;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_d1;
  logic [3:0] load_d0;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       carry_out;
  logic       borrow_out;
  logic       load_err;

  modport master (
    output en, up_dn, load, load_d1, load_d0,
    input  digit1, digit0, carry_out, borrow_out, load_err
  );

  modport slave (
    input  en, up_dn, load, load_d1, load_d0,
    output digit1, digit0, carry_out, borrow_out, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (MIN_VAL..MAX_VAL) with up/down stepping,
// validated preset load and registered carry/borrow/load_err pulses.
module bcd_mod_counter #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23
) (
  input  logic               clk,
  input  logic               reset,
  bcd_mod_counter_if.slave   bus
);

  if (MIN_VAL < 0 || MAX_VAL > 99 || MIN_VAL >= MAX_VAL) begin : g_bad_params
    $fatal(1, "bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
  end

  localparam logic [6:0] MIN_V  = 7'(MIN_VAL);
  localparam logic [6:0] MAX_V  = 7'(MAX_VAL);
  localparam logic [3:0] MIN_D1 = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_D0 = 4'(MIN_VAL % 10);

  logic [6:0] count_q, count_d;
  logic [3:0] digit1_q, digit1_d;
  logic [3:0] digit0_q, digit0_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       load_err_q, load_err_d;

  logic [6:0] preset;
  logic       above_min;
  logic       preset_ok;

  // Preset may overflow 7 bits for non-BCD nibbles, but the nibble checks
  // reject those cases before the value is ever used.
  assign preset = 7'(bus.load_d1) * 7'd10 + 7'(bus.load_d0);

  if (MIN_VAL == 0) begin : g_min_zero
    assign above_min = 1'b1;
  end else begin : g_min_nonzero
    assign above_min = (preset >= MIN_V);
  end

  assign preset_ok = (bus.load_d1 <= 4'd9) && (bus.load_d0 <= 4'd9) &&
                     above_min && (preset <= MAX_V);

  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (preset_ok) count_d = preset;
      else           load_err_d = 1'b1;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (count_q == MAX_V) begin
          count_d = MIN_V;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + 7'd1;
        end
      end else begin
        if (count_q == MIN_V) begin
          count_d  = MAX_V;
          borrow_d = 1'b1;
        end else begin
          count_d = count_q - 7'd1;
        end
      end
    end
    digit1_d = 4'(count_d / 7'd10);
    digit0_d = 4'(count_d % 7'd10);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= MIN_V;
      digit1_q   <= MIN_D1;
      digit0_q   <= MIN_D0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      digit1_q   <= digit1_d;
      digit0_q   <= digit0_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.digit1     = digit1_q;
  assign bus.digit0     = digit0_q;
  assign bus.carry_out  = carry_q;
  assign bus.borrow_out = borrow_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: vector table on the 0..23 counter, directed
// corner sequences on 1..12 and 0..59, then random traffic against a model.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bcd_mod_counter_if if_a();
  bcd_mod_counter_if if_b();
  bcd_mod_counter_if if_c();

  bcd_mod_counter u_a (.clk(clk), .reset(rst_a), .bus(if_a));
  bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_b (.clk(clk), .reset(rst_b), .bus(if_b));
  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_c (.clk(clk), .reset(rst_c), .bus(if_c));

  typedef struct {
    logic       ld, en, up;
    logic [3:0] d1, d0;
    logic [3:0] e1, e0;
    logic       ec, eb, ee;
  } vec_t;

  vec_t tbl[$];

  function automatic int pk(input int v, input int c, input int b, input int e);
    return ((v / 10) << 7) | ((v % 10) << 3) | (c << 2) | (b << 1) | e;
  endfunction

  // Reference: position within the modulus ring, advanced with % arithmetic.
  function automatic void model(input int mn, input int mx, input int ld, input int en,
                                input int up, input int d1, input int d0,
                                inout int v, output int c, output int b, output int e);
    int n;
    int p;
    n = mx - mn + 1;
    p = d1 * 10 + d0;
    c = 0; b = 0; e = 0;
    if (ld != 0) begin
      if (d1 <= 9 && d0 <= 9 && p >= mn && p <= mx) v = p;
      else e = 1;
    end else if (en != 0) begin
      if (up != 0) begin
        c = (v == mx) ? 1 : 0;
        v = mn + (v - mn + 1) % n;
      end else begin
        b = (v == mn) ? 1 : 0;
        v = mn + (v - mn - 1 + n) % n;
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got d=%0d%0d c/b/e=%0d%0d%0d want d=%0d%0d c/b/e=%0d%0d%0d", nm,
               (act >> 7) & 15, (act >> 3) & 15, (act >> 2) & 1, (act >> 1) & 1, act & 1,
               (exp >> 7) & 15, (exp >> 3) & 15, (exp >> 2) & 1, (exp >> 1) & 1, exp & 1);
    end
  endtask

  function automatic int out_a();
    return int'({if_a.digit1, if_a.digit0, if_a.carry_out, if_a.borrow_out, if_a.load_err});
  endfunction
  function automatic int out_b();
    return int'({if_b.digit1, if_b.digit0, if_b.carry_out, if_b.borrow_out, if_b.load_err});
  endfunction
  function automatic int out_c();
    return int'({if_c.digit1, if_c.digit0, if_c.carry_out, if_c.borrow_out, if_c.load_err});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic ld, input logic en, input logic up,
                       input logic [3:0] d1, input logic [3:0] d0);
    if_a.load = ld; if_a.en = en; if_a.up_dn = up; if_a.load_d1 = d1; if_a.load_d0 = d0;
  endtask
  task automatic drv_b(input logic ld, input logic en, input logic up,
                       input logic [3:0] d1, input logic [3:0] d0);
    if_b.load = ld; if_b.en = en; if_b.up_dn = up; if_b.load_d1 = d1; if_b.load_d0 = d0;
  endtask
  task automatic drv_c(input logic ld, input logic en, input logic up,
                       input logic [3:0] d1, input logic [3:0] d0);
    if_c.load = ld; if_c.en = en; if_c.up_dn = up; if_c.load_d1 = d1; if_c.load_d0 = d0;
  endtask

  function automatic vec_t mk(input logic ld, input logic en, input logic up,
                              input int d1, input int d0, input int v,
                              input logic ec, input logic eb, input logic ee);
    vec_t r;
    r.ld = ld; r.en = en; r.up = up;
    r.d1 = 4'(d1); r.d0 = 4'(d0);
    r.e1 = 4'(v / 10); r.e0 = 4'(v % 10);
    r.ec = ec; r.eb = eb; r.ee = ee;
    return r;
  endfunction

  initial begin
    int va, vb, vc, c, b, e;
    int ld, en, up, d1, d0;

    for (int i = 1; i <= 24; i++) tbl.push_back(mk(0, 1, 1, 0, 0, i % 24, i == 24, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 7, 7, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 2, 4, 7, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 10, 7, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 2, 2, 22, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 5, 15, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 16, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 14, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 23, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 9, 9, 0, 0, 0, 1));

    drv_a(0, 0, 1, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    drv_c(0, 0, 1, 0, 0);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #10;
    chk("reset_a", out_a(), pk(0, 0, 0, 0));
    chk("reset_b", out_b(), pk(1, 0, 0, 0));
    chk("reset_c", out_c(), pk(0, 0, 0, 0));
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
    chk("release_hold_a", out_a(), pk(0, 0, 0, 0));

    foreach (tbl[i]) begin
      drv_a(tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].d1, tbl[i].d0);
      tick();
      chk($sformatf("tbl_a[%0d]", i), out_a(),
          int'({tbl[i].e1, tbl[i].e0, tbl[i].ec, tbl[i].eb, tbl[i].ee}));
    end

    // 12 h counter: down from the minimum wraps to 12 with a borrow.
    drv_a(0, 0, 1, 0, 0);
    drv_b(0, 1, 0, 0, 0);
    tick();
    chk("b_wrap_down", out_b(), pk(12, 0, 1, 0));
    tick();
    chk("b_down_11", out_b(), pk(11, 0, 0, 0));
    drv_b(1, 0, 0, 0, 0);
    tick();
    chk("b_load_below_min", out_b(), pk(11, 0, 0, 1));
    drv_b(0, 0, 0, 0, 0);
    tick();
    chk("b_err_clears", out_b(), pk(11, 0, 0, 0));

    drv_c(1, 0, 1, 5, 8);
    tick();
    chk("c_load_58", out_c(), pk(58, 0, 0, 0));
    drv_c(0, 1, 1, 0, 0);
    tick();
    chk("c_59", out_c(), pk(59, 0, 0, 0));
    tick();
    chk("c_wrap_00", out_c(), pk(0, 1, 0, 0));
    drv_c(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("c_hold[%0d]", k), out_c(), pk(0, 0, 0, 0));
    end

    // Reset asserted just before a wrapping edge must win over en.
    drv_a(1, 0, 1, 2, 3);
    tick();
    chk("a_load_23", out_a(), pk(23, 0, 0, 0));
    drv_a(0, 1, 1, 0, 0);
    @(negedge clk);
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_async_reset", out_a(), pk(0, 0, 0, 0));
    tick();
    chk("a_reset_held", out_a(), pk(0, 0, 0, 0));
    @(negedge clk);
    rst_a = 1'b1;
    tick();
    chk("a_after_release", out_a(), pk(1, 0, 0, 0));

    va = 1; vb = 11; vc = 0;
    for (int k = 0; k < 600; k++) begin
      ld = ($urandom_range(0, 7) == 0) ? 1 : 0;
      en = ($urandom_range(0, 3) != 0) ? 1 : 0;
      up = int'($urandom_range(0, 1));
      d1 = int'($urandom_range(0, 11));
      d0 = int'($urandom_range(0, 11));
      drv_a(ld[0], en[0], up[0], 4'(d1), 4'(d0));
      model(0, 23, ld, en, up, d1, d0, va, c, b, e);
      ld = ($urandom_range(0, 7) == 0) ? 1 : 0;
      en = ($urandom_range(0, 3) != 0) ? 1 : 0;
      up = int'($urandom_range(0, 1));
      d1 = int'($urandom_range(0, 2));
      d0 = int'($urandom_range(0, 11));
      drv_b(ld[0], en[0], up[0], 4'(d1), 4'(d0));
      tick();
      chk($sformatf("rand_a[%0d]", k), out_a(), pk(va, c, b, e));
      model(1, 12, ld, en, up, d1, d0, vb, c, b, e);
      chk($sformatf("rand_b[%0d]", k), out_b(), pk(vb, c, b, e));
      model(0, 59, 0, 0, 1, 0, 0, vc, c, b, e);
      chk($sformatf("idle_c[%0d]", k), out_c(), pk(vc, c, b, e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter for the digital clock/timer chain.
- Supersedes the fixed 0..23 hour counter; one block covers:
  - seconds/minutes: MIN_VAL=0, MAX_VAL=59
  - 24 h hours: 0..23
  - 12 h hours: 1..12
- Adds count enable, up/down direction, synchronous preset load with validation, and separate carry/borrow pulses for cascading.
- Runs on the single system clock; advances only on qualified enable ticks.

Parameters:
- MIN_VAL, 0, lowest count value (decimal, 0..98).
- MAX_VAL, 23, highest count value (decimal, MIN_VAL+1..99).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count tick; one step per clk edge while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled when en=1.
- load  input  1  synchronous preset strobe; priority over en.
- load_d1  input  4  preset tens digit (BCD).
- load_d0  input  4  preset units digit (BCD).
- digit1  output  4  tens digit of current value (BCD).
- digit0  output  4  units digit of current value (BCD).
- carry_out  output  1  one-cycle pulse on up-wrap.
- borrow_out  output  1  one-cycle pulse on down-wrap.
- load_err  output  1  one-cycle pulse on a rejected preset.

Behaviour:
- Reset (reset=0, asynchronous): value=MIN_VAL; digit1/digit0 = BCD of MIN_VAL; carry_out=0, borrow_out=0, load_err=0. Release is synchronous to clk via the normal flop path; no count on the release edge unless en=1 after it.
- Internal state: 7-bit binary count. Digits are registered and updated on the same edge as count from the next value: tens = next/10, units = next%10. Value-to-output latency is 0 cycles after the edge.
- Per-edge priority: load > en > hold.
- load=1:
  - Valid when load_d1<=9, load_d0<=9, and MIN_VAL <= 10*load_d1+load_d0 <= MAX_VAL.
  - Valid: count takes the preset; carry_out=0, borrow_out=0, load_err=0.
  - Invalid: count unchanged; load_err=1 for one cycle; carry/borrow 0.
  - en is ignored on any load edge.
- en=1, load=0, up_dn=1:
  - count==MAX_VAL -> count=MIN_VAL, carry_out=1.
  - else count+1, carry_out=0.
- en=1, load=0, up_dn=0:
  - count==MIN_VAL -> count=MAX_VAL, borrow_out=1.
  - else count-1, borrow_out=0.
- en=0, load=0: count holds; all pulse outputs 0.
- Pulse timing: carry_out/borrow_out/load_err are registered. Each is high for exactly the cycle following the causing edge, coincident with the wrapped/held digits. They deassert on the next edge regardless of en.
- Cascading: the downstream stage en is driven by the upstream carry_out (up) or borrow_out (down). With en held high continuously, pulses occur once per (MAX_VAL-MIN_VAL+1) ticks.
- up_dn changes take effect on the next en edge; there is no pipeline.
- Reset asserted mid-operation overrides load/en immediately and clears pending pulses.
- Elaboration: violating 0<=MIN_VAL<MAX_VAL<=99 is a fatal elaboration error.

Test Plan:
- Default params, reset low then high, en=1 for 24 edges, up_dn=1: digits step 00,01..09,10..23, then 00. carry_out=1 only in the cycle showing 00 after 23; reset state is 00, all pulses 0.
- MIN_VAL=1, MAX_VAL=12, up_dn=0 from reset (01), one en edge: digits 12, borrow_out=1 for one cycle. Next en edge: 11, borrow_out=0.
- MIN_VAL=0, MAX_VAL=59: load with d1=5, d0=8, then en=1 two edges: 58 -> 59 -> 00 with carry_out pulse. Then en=0 for 3 cycles: digits hold 00, carry_out=0.
- Invalid loads on the default counter, value 07:
  - d1=2, d0=4 (24 > MAX_VAL): digits stay 07, load_err=1 one cycle.
  - d1=0, d0=10 (nibble >9): same, load_err=1, digits 07.
  - 12 h config, d1=0, d0=0 (below MIN_VAL=1): load_err=1, digits unchanged.
- Simultaneous load=1 (preset 15) and en=1 at 22: digits become 15, no carry. Following en edge gives 16.
- Count at 23 with en=1; assert reset mid-cycle before the edge: digits go to 00 asynchronously, carry_out stays 0. After release, next en edge gives 01.
